// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - sequential AES InvSubBytes, one 32-bit column per cycle

// Combinational FIPS-197 inverse S-box lookup.
module inv_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign data = INV_SBOX[addr];

endmodule

// Captures one state block, substitutes a column per cycle, then holds the result until taken.
module inv_sub_bytes_seq #(
  parameter int STATE_WIDTH = 128,
  parameter int WORD_WIDTH  = 32,
  parameter int BYTE_SIZE   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [STATE_WIDTH-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_WIDTH-1:0] out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [STATE_WIDTH-1:0] in_buf_q, in_buf_d;
  logic [STATE_WIDTH-1:0] out_state_q, out_state_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  logic [WORD_WIDTH-1:0]  cur_word;
  logic [WORD_WIDTH-1:0]  sub_word;

  // Select the captured column addressed by the counter; word0 is the top 32 bits.
  always_comb begin
    cur_word = in_buf_q[STATE_WIDTH-1 -: WORD_WIDTH];
    case (cnt_q)
      2'd0: cur_word = in_buf_q[STATE_WIDTH-1              -: WORD_WIDTH];
      2'd1: cur_word = in_buf_q[STATE_WIDTH-1-WORD_WIDTH   -: WORD_WIDTH];
      2'd2: cur_word = in_buf_q[STATE_WIDTH-1-2*WORD_WIDTH -: WORD_WIDTH];
      2'd3: cur_word = in_buf_q[STATE_WIDTH-1-3*WORD_WIDTH -: WORD_WIDTH];
      default: cur_word = in_buf_q[STATE_WIDTH-1 -: WORD_WIDTH];
    endcase
  end

  for (genvar g = 0; g < WORD_WIDTH / BYTE_SIZE; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .addr (cur_word[WORD_WIDTH-1-BYTE_SIZE*g -: BYTE_SIZE]),
      .data (sub_word[WORD_WIDTH-1-BYTE_SIZE*g -: BYTE_SIZE])
    );
  end

  // Next-state logic: clear overrides everything; inputs only matter in IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_buf_d    = in_buf_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    if (clear) begin
      state_d     = IDLE;
      cnt_d       = 2'd0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_d = 1'b1;
          if (in_valid && in_ready_q) begin
            in_buf_d   = in_state;
            cnt_d      = 2'd0;
            state_d    = RUN;
            in_ready_d = 1'b0;
          end
        end
        RUN: begin
          in_ready_d = 1'b0;
          case (cnt_q)
            2'd0: out_state_d[STATE_WIDTH-1              -: WORD_WIDTH] = sub_word;
            2'd1: out_state_d[STATE_WIDTH-1-WORD_WIDTH   -: WORD_WIDTH] = sub_word;
            2'd2: out_state_d[STATE_WIDTH-1-2*WORD_WIDTH -: WORD_WIDTH] = sub_word;
            2'd3: out_state_d[STATE_WIDTH-1-3*WORD_WIDTH -: WORD_WIDTH] = sub_word;
            default: out_state_d = out_state_q;
          endcase
          // Counter wraps to 0 on the last column, ready for the next block.
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end
        end
        DONE: begin
          in_ready_d = 1'b0;
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = 2'd0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      in_buf_q    <= '0;
      out_state_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_buf_q    <= in_buf_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb/tb_inv_sub_bytes_seq.sv - directed and scoreboard bench for inv_sub_bytes_seq

module tb_inv_sub_bytes_seq;

  localparam logic [127:0] FIPS_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] FIPS_OUT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CORN_IN  = {4{32'h00ff1663}};
  localparam logic [127:0] CORN_OUT = {4{32'h527dff00}};
  localparam int           N_RAND   = 10000;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_vec;
  int n_err;

  logic [7:0]   ref_inv [256];
  logic [127:0] exp_q [$];

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    logic       hi;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Reference table derived from GF(2^8) inversion plus the forward affine map.
  task automatic build_ref();
    logic [7:0] x;
    logic [7:0] inv;
    logic [7:0] s;
    for (int v = 0; v < 256; v++) begin
      x   = v[7:0];
      inv = 8'h01;
      if (x == 8'h00) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      else begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_inv[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = ref_inv[s[127-8*i -: 8]];
    return r;
  endfunction

  task automatic start_block(input logic [127:0] st);
    in_valid = 1'b1;
    in_state = st;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (out_state !== 128'h0) begin n_err++; $display("FAIL reset_out_state got %h want 0", out_state); end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_fips();
    int n;
    start_block(FIPS_IN);
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL fips_run_in_ready got %b want 0", in_ready); end
    wait_valid(n);
    n_vec++;
    if (n !== 4) begin n_err++; $display("FAIL fips_latency got %0d want 4", n); end
    n_vec++;
    if (out_state !== FIPS_OUT) begin n_err++; $display("FAIL fips_value got %h want %h", out_state, FIPS_OUT); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL fips_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    n_vec++;
    if (out_state !== FIPS_OUT) begin n_err++; $display("FAIL fips_hold_after got %h want %h", out_state, FIPS_OUT); end
  endtask

  task automatic test_corners();
    int n;
    start_block(CORN_IN);
    wait_valid(n);
    n_vec++;
    if (n !== 4) begin n_err++; $display("FAIL corner_latency got %0d want 4", n); end
    n_vec++;
    if (out_state !== CORN_OUT) begin n_err++; $display("FAIL corner_value got %h want %h", out_state, CORN_OUT); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    start_block(FIPS_IN);
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== FIPS_OUT) begin
        n_err++;
        $display("FAIL backpressure_hold cycle %0d got valid=%b ready=%b state=%h want 1/0/%h", c, out_valid, in_ready, out_state, FIPS_OUT);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignored_input();
    int n;
    int seen;
    start_block(FIPS_IN);
    in_valid = 1'b1;
    in_state = CORN_IN;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    n_vec++;
    if (out_state !== FIPS_OUT) begin n_err++; $display("FAIL ignored_value got %h want %h", out_state, FIPS_OUT); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL ignored_second_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_abort();
    int n;
    int seen;
    start_block(CORN_IN);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL abort_state got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    n_vec++;
    if (out_state !== {32'h527dff00, 96'h0405060708090a0b0c0d0e0f}) begin
      n_err++; $display("FAIL abort_partial got %h want %h", out_state, {32'h527dff00, 96'h0405060708090a0b0c0d0e0f});
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL abort_no_output got %0d valid cycles want 0", seen); end
    start_block(FIPS_IN);
    wait_valid(n);
    n_vec++;
    if (n !== 4 || out_state !== FIPS_OUT) begin
      n_err++; $display("FAIL abort_recover got lat=%0d state=%h want 4/%h", n, out_state, FIPS_OUT);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_clear_priority();
    int seen;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_state = CORN_IN;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL clear_idle_ready got %b want 1", in_ready); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL clear_idle_capture got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_async_reset();
    int n;
    start_block(CORN_IN);
    wait_valid(n);
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL areset_immediate got valid=%b ready=%b state=%h want 0/0/0", out_valid, in_ready, out_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL areset_idle got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random_scoreboard();
    int           pushed;
    int           popped;
    int           cyc;
    logic         take_new;
    logic [127:0] e;
    pushed   = 0;
    popped   = 0;
    cyc      = 0;
    take_new = 1'b1;
    while (popped < N_RAND && cyc < 90000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (pushed < N_RAND);
      if (take_new) in_state = {$urandom, $urandom, $urandom, $urandom};
      take_new = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_block(in_state));
        pushed++;
        take_new = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected_output got %h want none", out_state);
        end else begin
          e = exp_q.pop_front();
          if (out_state !== e) begin n_err++; $display("FAIL rand_value block %0d got %h want %h", popped, out_state, e); end
        end
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (popped !== N_RAND || exp_q.size() !== 0) begin
      n_err++; $display("FAIL rand_completion got %0d blocks (%0d pending) want %0d", popped, exp_q.size(), N_RAND);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_state  = 128'h0;
    out_ready = 1'b0;
    build_ref();
    test_reset();
    test_fips();
    test_corners();
    test_backpressure();
    test_ignored_input();
    test_abort();
    test_clear_priority();
    test_async_reset();
    test_random_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
